// File: rtl/demux16_router.sv
// demux16_router: registered 1-to-3 demultiplexer with a valid/ready handshake on each output.
// in_sel selects the destination: 00 -> A, 01 -> B, 10 -> C, 11 -> discard.
// Each destination is a one-entry output register. It can drain and refill in the same cycle,
// so every slot sustains one word per cycle.
// Optional feature macro: DEMUX16_DROP_CNT_EN adds a saturating count of discarded transfers.
// When the macro is undefined, drop_cnt is tied to zero.
module demux16_router #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic             out_a_valid,
  output logic             out_b_valid,
  output logic             out_c_valid,
  input  logic             out_a_ready,
  input  logic             out_b_ready,
  input  logic             out_c_ready,
  output logic [7:0]       drop_cnt
);

  logic [WIDTH-1:0] r_a_data, r_b_data, r_c_data;
  logic             r_a_valid, r_b_valid, r_c_valid;

  logic w_free_a, w_free_b, w_free_c;
  logic w_accept;
  logic w_fill_a, w_fill_b, w_fill_c;
  logic w_drop;

  // A slot can take new data when it is empty or is being consumed this cycle.
  always_comb begin
    w_free_a = !r_a_valid || out_a_ready;
    w_free_b = !r_b_valid || out_b_ready;
    w_free_c = !r_c_valid || out_c_ready;
  end

  // in_ready depends only on the select and the state of the selected slot, never on in_valid.
  always_comb begin
    in_ready = 1'b0;
    unique case (in_sel)
      2'b00:   in_ready = w_free_a;
      2'b01:   in_ready = w_free_b;
      2'b10:   in_ready = w_free_c;
      default: in_ready = 1'b1;
    endcase
  end

  // Decode which slot is filled by an accepted transfer.
  always_comb begin
    w_accept = in_valid && in_ready;
    w_fill_a = w_accept && (in_sel == 2'b00);
    w_fill_b = w_accept && (in_sel == 2'b01);
    w_fill_c = w_accept && (in_sel == 2'b10);
    w_drop   = w_accept && (in_sel == 2'b11);
  end

  // Slot registers. A fill wins over a drain, so a simultaneous drain and fill keeps valid high.
  // A drain clears only the valid bit and leaves the data in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_data  <= '0;
      r_b_data  <= '0;
      r_c_data  <= '0;
      r_a_valid <= 1'b0;
      r_b_valid <= 1'b0;
      r_c_valid <= 1'b0;
    end else begin
      if (w_fill_a) begin
        r_a_data  <= in_data;
        r_a_valid <= 1'b1;
      end else if (r_a_valid && out_a_ready) begin
        r_a_valid <= 1'b0;
      end
      if (w_fill_b) begin
        r_b_data  <= in_data;
        r_b_valid <= 1'b1;
      end else if (r_b_valid && out_b_ready) begin
        r_b_valid <= 1'b0;
      end
      if (w_fill_c) begin
        r_c_data  <= in_data;
        r_c_valid <= 1'b1;
      end else if (r_c_valid && out_c_ready) begin
        r_c_valid <= 1'b0;
      end
    end
  end

`ifdef DEMUX16_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  // Count discarded transfers, saturating at 8'hFF. Only rst clears the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= 8'h00;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'h01;
    end
  end

  // Present the discard count.
  always_comb drop_cnt = r_drop_cnt;
`else
  logic w_unused_drop;

  // Without the counter, drop_cnt is tied to zero.
  always_comb begin
    w_unused_drop = w_drop;
    drop_cnt      = 8'h00;
  end
`endif

  // Present the slot registers on the output ports.
  always_comb begin
    out_a       = r_a_data;
    out_b       = r_b_data;
    out_c       = r_c_data;
    out_a_valid = r_a_valid;
    out_b_valid = r_b_valid;
    out_c_valid = r_c_valid;
  end

endmodule

// File: tb/tb_demux16_router.sv
// tb_demux16_router: directed test of demux16_router using hand-computed expectations.
// Inputs change 1 ns after a rising edge. in_ready is checked 1 ns after the inputs change.
// Registered outputs are checked 1 ns after the next rising edge.
module tb_demux16_router;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_a, out_b, out_c;
  logic        out_a_valid, out_b_valid, out_c_valid;
  logic        out_a_ready, out_b_ready, out_c_ready;
  logic [7:0]  drop_cnt;

  int checks;
  int failures;

  logic [7:0] exp_drop_one;
  logic [7:0] exp_drop_sat;

  demux16_router #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_sel      (in_sel),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_c       (out_c),
    .out_a_valid (out_a_valid),
    .out_b_valid (out_b_valid),
    .out_c_valid (out_c_valid),
    .out_a_ready (out_a_ready),
    .out_b_ready (out_b_ready),
    .out_c_ready (out_c_ready),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef DEMUX16_DROP_CNT_EN
    exp_drop_one = 8'h01;
    exp_drop_sat = 8'hFF;
`else
    exp_drop_one = 8'h00;
    exp_drop_sat = 8'h00;
`endif

    // Reset with a transfer offered at the same time.
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'b00; in_data = 16'hFFFF;
    out_a_ready = 1'b0; out_b_ready = 1'b0; out_c_ready = 1'b0;
    tick();
    check("rst_a_valid", 32'(out_a_valid), 32'h0);
    check("rst_b_valid", 32'(out_b_valid), 32'h0);
    check("rst_c_valid", 32'(out_c_valid), 32'h0);
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_out_b", 32'(out_b), 32'h0);
    check("rst_out_c", 32'(out_c), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    rst = 1'b0;

    // Single route to B, then a second offer to the stalled B slot.
    in_data = 16'hBEEF; in_sel = 2'b01; in_valid = 1'b1;
    #1 check("route_b_ready", 32'(in_ready), 32'h1);
    tick();
    check("route_b_data", 32'(out_b), 32'hBEEF);
    check("route_b_valid", 32'(out_b_valid), 32'h1);
    check("route_a_idle", 32'(out_a_valid), 32'h0);
    check("route_c_idle", 32'(out_c_valid), 32'h0);
    in_data = 16'hCAFE;
    #1 check("stall_b_ready", 32'(in_ready), 32'h0);
    tick();
    check("stall_b_hold", 32'(out_b), 32'hBEEF);
    check("stall_b_valid", 32'(out_b_valid), 32'h1);

    // Back-to-back transfers to C with C always ready.
    out_c_ready = 1'b1; in_sel = 2'b10;
    in_data = 16'h0001;
    #1 check("b2b_ready_1", 32'(in_ready), 32'h1);
    tick();
    check("b2b_data_1", 32'(out_c), 32'h0001);
    check("b2b_valid_1", 32'(out_c_valid), 32'h1);
    in_data = 16'h0002;
    #1 check("b2b_ready_2", 32'(in_ready), 32'h1);
    tick();
    check("b2b_data_2", 32'(out_c), 32'h0002);
    check("b2b_valid_2", 32'(out_c_valid), 32'h1);
    in_data = 16'h0003;
    #1 check("b2b_ready_3", 32'(in_ready), 32'h1);
    tick();
    check("b2b_data_3", 32'(out_c), 32'h0003);
    check("b2b_valid_3", 32'(out_c_valid), 32'h1);
    // With no new input, C drains and keeps its last data.
    in_valid = 1'b0;
    tick();
    check("drain_c_valid", 32'(out_c_valid), 32'h0);
    check("drain_c_hold", 32'(out_c), 32'h0003);
    out_c_ready = 1'b0;

    // Independent stall: fill A, offer A again (blocked), then send to C.
    in_valid = 1'b1; in_sel = 2'b00; in_data = 16'h1111;
    tick();
    check("fill_a_data", 32'(out_a), 32'h1111);
    in_data = 16'h1234;
    #1 check("indep_a_ready", 32'(in_ready), 32'h0);
    tick();
    check("indep_a_hold", 32'(out_a), 32'h1111);
    in_sel = 2'b10; in_data = 16'h5678;
    #1 check("indep_c_ready", 32'(in_ready), 32'h1);
    tick();
    check("indep_c_data", 32'(out_c), 32'h5678);
    check("indep_c_valid", 32'(out_c_valid), 32'h1);
    check("indep_a_same", 32'(out_a), 32'h1111);
    check("indep_b_same", 32'(out_b), 32'hBEEF);

    // Discard path is accepted even while every slot is stalled.
    in_sel = 2'b11; in_data = 16'hDEAD;
    #1 check("disc_ready", 32'(in_ready), 32'h1);
    tick();
    check("disc_cnt_1", 32'(drop_cnt), 32'(exp_drop_one));
    for (int i = 0; i < 299; i++) tick();
    check("disc_cnt_sat", 32'(drop_cnt), 32'(exp_drop_sat));
    check("disc_a_same", 32'(out_a), 32'h1111);
    check("disc_b_same", 32'(out_b), 32'hBEEF);
    check("disc_c_same", 32'(out_c), 32'h5678);
    check("disc_valids", 32'({out_a_valid, out_b_valid, out_c_valid}), 32'h7);

    // in_valid=0 never fills a slot. A drains and keeps its data.
    in_valid = 1'b0; in_sel = 2'b00; in_data = 16'h4242; out_a_ready = 1'b1;
    tick();
    check("novalid_a_valid", 32'(out_a_valid), 32'h0);
    check("novalid_a_hold", 32'(out_a), 32'h1111);
    out_a_ready = 1'b0;

    // Simultaneous drain and fill of B, then reset while a handshake is in flight.
    in_valid = 1'b1; in_sel = 2'b01; in_data = 16'h00AA; out_b_ready = 1'b1;
    #1 check("df_b_ready", 32'(in_ready), 32'h1);
    tick();
    check("df_b_data", 32'(out_b), 32'h00AA);
    check("df_b_valid", 32'(out_b_valid), 32'h1);
    out_b_ready = 1'b0; in_valid = 1'b0;
    tick();
    check("hold_b_aa", 32'(out_b), 32'h00AA);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h9999; out_b_ready = 1'b1;
    tick();
    check("mid_rst_b_valid", 32'(out_b_valid), 32'h0);
    check("mid_rst_b_data", 32'(out_b), 32'h0);
    check("mid_rst_c_valid", 32'(out_c_valid), 32'h0);
    check("mid_rst_drop", 32'(drop_cnt), 32'h0);
    rst = 1'b0; out_b_ready = 1'b0; in_data = 16'h00BB;
    #1 check("post_rst_ready", 32'(in_ready), 32'h1);
    tick();
    check("post_rst_b_data", 32'(out_b), 32'h00BB);
    check("post_rst_b_valid", 32'(out_b_valid), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
